serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_sub_cell.sv | 13 +
 rtl/serial_subtractor.sv | 152 +++++++++++++++
 tb/tb_serial_subtractor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Wide enough to hold the value BITWIDTH itself, so the step count never wraps.
    function automatic int cnt_width(input int bw);
        return $clog2(bw + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_cell.sv
// One-bit full subtractor evaluated once per bit-step by the serial datapath.
module sub_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, with valid/ready handshakes on both sides.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic                bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] d,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic                ovf,
`endif
    output logic                bout
);

    localparam int              CNT_W     = cnt_width(BITWIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BITWIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    sub_state_t          state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [BITWIDTH-1:0] a_sh_q, a_sh_d;
    logic [BITWIDTH-1:0] b_sh_q, b_sh_d;
    logic [BITWIDTH-1:0] d_q, d_d;
    logic                borrow_q, borrow_d;
    logic                bout_q, bout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cell_diff_s, cell_bo_s;
    logic                accept_s, last_step_s;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic                ovf_q, ovf_d;
`endif

    sub_cell u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bi   (borrow_q),
        .diff (cell_diff_s),
        .bo   (cell_bo_s)
    );

    assign accept_s    = (state_q == IDLE) && in_valid && in_ready_q;
    assign last_step_s = (cnt_q == LAST_STEP);

    // Next-state logic; handshake flags are registered from the next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = BUSY;
                else          state_d = IDLE;
            end
            BUSY: begin
                if (last_step_s) state_d = DONE;
                else             state_d = BUSY;
            end
            DONE: begin
                if (out_valid_q && out_ready) state_d = IDLE;
                else                          state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Datapath: load on accept, shift one bit per BUSY cycle, hold otherwise.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (accept_s) begin
            a_sh_d   = a;
            b_sh_d   = b;
            borrow_d = bin;
            cnt_d    = '0;
        end else if (state_q == BUSY) begin
            a_sh_d             = a_sh_q >> 1'b1;
            b_sh_d             = b_sh_q >> 1'b1;
            d_d                = d_q >> 1'b1;
            d_d[BITWIDTH-1]    = cell_diff_s;
            borrow_d           = cell_bo_s;
            cnt_d              = cnt_q + CNT_ONE;
            // The MSB step also latches the final borrow (and overflow) into the result.
            if (last_step_s) begin
                bout_d = cell_bo_s;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                ovf_d  = borrow_q ^ cell_bo_s;
`endif
            end else begin
                bout_d = bout_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            cnt_q       <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            d_q         <= d_d;
            borrow_q    <= borrow_d;
            bout_q      <= bout_d;
            cnt_q       <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bout      = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor at BITWIDTH=8 and BITWIDTH=1.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, bin, bout;
    logic [W-1:0] a, b, d;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, bin1, bout1;
    logic [0:0]   a1, b1, d1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf, ovf1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.BITWIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf       (ovf),
`endif
        .bout      (bout)
    );

    serial_subtractor #(.BITWIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .bin       (bin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .d         (d1),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf       (ovf1),
`endif
        .bout      (bout1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic straight from the definition of subtraction with borrow.
    function automatic logic [63:0] ref_d(input int bw, input longint unsigned av,
                                          input longint unsigned bv, input logic bi);
        longint unsigned mask;
        mask = (64'd1 << bw) - 64'd1;
        return (av - bv - 64'(bi)) & mask;
    endfunction

    function automatic logic ref_bout(input longint unsigned av, input longint unsigned bv,
                                      input logic bi);
        return av < (bv + 64'(bi));
    endfunction

    function automatic logic ref_ovf(input int bw, input longint unsigned av,
                                     input longint unsigned bv, input logic bi);
        longint half, sa, sb, r;
        half = longint'(64'd1 << (bw - 1));
        sa   = (av >= 64'(half)) ? longint'(av) - 2 * half : longint'(av);
        sb   = (bv >= 64'(half)) ? longint'(bv) - 2 * half : longint'(bv);
        r    = sa - sb - longint'(64'(bi));
        return (r < -half) || (r > half - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op8(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input int stall);
        logic [63:0] ed;
        logic        eb, ok;
        int          lat;
        ed  = ref_d(W, 64'(av), 64'(bv), bi);
        eb  = ref_bout(64'(av), 64'(bv), bi);
        lat = 0;
        while (!in_ready && lat < 50) begin
            step();
            lat++;
        end
        check_eq("ready_before_op", 64'(in_ready), 64'(1'b1));
        a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = 1'b0;
        step();
        ok  = 1'b1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            ok &= (in_ready == 1'b0);
            scramble();
            out_ready = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        out_ready = 1'b0;
        check_eq("latency", 64'(lat), 64'(W));
        check_eq("busy_not_ready", 64'(ok), 64'(1'b1));
        check_eq("d", 64'(d), ed);
        check_eq("bout", 64'(bout), 64'(eb));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check_eq("ovf", 64'(ovf), 64'(ref_ovf(W, 64'(av), 64'(bv), bi)));
`endif
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            scramble();
            step();
            ok &= (64'(d) == ed) && (bout == eb) && out_valid && !in_ready;
        end
        if (stall > 0) check_eq("stall_stable", 64'(ok), 64'(1'b1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("valid_drop", 64'(out_valid), 64'(1'b0));
        check_eq("ready_after_hs", 64'(in_ready), 64'(1'b1));
    endtask

    task automatic do_op1(input logic av, input logic bv, input logic bi);
        int lat;
        lat = 0;
        while (!in_ready1 && lat < 20) begin
            step();
            lat++;
        end
        check_eq("w1_ready", 64'(in_ready1), 64'(1'b1));
        a1 = av; b1 = bv; bin1 = bi; in_valid1 = 1'b1; out_ready1 = 1'b0;
        step();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            step();
            lat++;
        end
        check_eq("w1_latency", 64'(lat), 64'd1);
        check_eq("w1_d", 64'(d1), ref_d(1, 64'(av), 64'(bv), bi));
        check_eq("w1_bout", 64'(bout1), 64'(ref_bout(64'(av), 64'(bv), bi)));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check_eq("w1_ovf", 64'(ovf1), 64'(ref_ovf(1, 64'(av), 64'(bv), bi)));
`endif
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check_eq("w1_ready_after_hs", 64'(in_ready1), 64'(1'b1));
    endtask

    initial begin
        logic ok;
        logic [2:0] combo;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (3) step();
        check_eq("rst_in_ready", 64'(in_ready), 64'(1'b0));
        check_eq("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check_eq("rst_d", 64'(d), 64'd0);
        check_eq("rst_bout", 64'(bout), 64'(1'b0));
        rst = 1'b0;
        step();
        check_eq("ready_after_rst", 64'(in_ready), 64'(1'b1));
        check_eq("w1_ready_after_rst", 64'(in_ready1), 64'(1'b1));

        do_op8(8'h05, 8'h03, 1'b0, 0);
        do_op8(8'h00, 8'h01, 1'b0, 0);
        do_op8(8'h10, 8'h0F, 1'b1, 0);
        do_op8(8'h80, 8'h01, 1'b0, 0);
        do_op8(8'h7F, 8'h01, 1'b0, 0);
        do_op8(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 20);

        // Reset three cycles into an operation must drop it silently.
        in_valid = 1'b1; a = 8'h55; b = 8'h22; bin = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        check_eq("midrst_out_valid", 64'(out_valid), 64'(1'b0));
        check_eq("midrst_in_ready", 64'(in_ready), 64'(1'b0));
        check_eq("midrst_d", 64'(d), 64'd0);
        rst = 1'b0;
        step();
        check_eq("midrst_ready_after", 64'(in_ready), 64'(1'b1));
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ok &= !out_valid;
            step();
        end
        check_eq("midrst_no_valid", 64'(ok), 64'(1'b1));
        do_op8(8'h09, 8'h04, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            do_op1(combo[2], combo[1], combo[0]);
        end

        for (int i = 0; i < 40; i++) begin
            do_op8(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
        end
        do_op8(8'h00, 8'h00, 1'b0, 0);
        do_op8(8'hFF, 8'hFF, 1'b1, 1);
        do_op8(8'h00, 8'hFF, 1'b1, 0);
        do_op8(8'hFF, 8'h00, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
